// File: rtl/l2_fence_ctrl.sv
// rtl/l2_fence_ctrl.sv - L2 fence sequencer: drain walk, writeback wait, self-invalidate walk
module l2_fence_ctrl #(
    parameter int L2_SETS     = 256,
    parameter int L2_WAYS     = 8,
    parameter int SET_BITS    = 8,
    parameter int WAY_BITS    = 3,
    parameter int WB_CNT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fence_start,
    input  logic                fence_rel,
    input  logic                fence_acq,
    output logic                walk_valid,
    input  logic                walk_ready,
    output logic [SET_BITS-1:0] walk_set,
    output logic [WAY_BITS-1:0] walk_way,
    output logic                walk_inv,
    input  logic                wb_issued,
    input  logic                wb_acked,
    input  logic                clr_ongoing_drain,
    output logic                ongoing_fence,
    output logic                drain_in_progress,
    output logic                ongoing_drain,
    output logic                fence_done,
    output logic                wb_err
);

    localparam int IDX_BITS = SET_BITS + WAY_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(L2_SETS * L2_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN_WALK,
        DRAIN_WAIT,
        INV_WALK,
        DONE
    } state_t;

    state_t                 state;
    logic                   acq_pend;
    logic [IDX_BITS-1:0]    walk_idx;
    logic [WB_CNT_BITS-1:0] wb_cnt;

    // way is the low field so the flat index walks every way of a set before moving on
    assign walk_set = walk_idx[IDX_BITS-1:WAY_BITS];
    assign walk_way = walk_idx[WAY_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            acq_pend          <= 1'b0;
            walk_idx          <= '0;
            walk_valid        <= 1'b0;
            walk_inv          <= 1'b0;
            ongoing_fence     <= 1'b0;
            drain_in_progress <= 1'b0;
            ongoing_drain     <= 1'b0;
            fence_done        <= 1'b0;
        end else begin
            fence_done <= 1'b0;
            // a set later in this block overrides the clear
            if (clr_ongoing_drain) begin
                ongoing_drain <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fence_start) begin
                        walk_idx <= '0;
                        if (fence_rel) begin
                            acq_pend          <= fence_acq;
                            state             <= DRAIN_WALK;
                            walk_valid        <= 1'b1;
                            walk_inv          <= 1'b0;
                            ongoing_fence     <= 1'b1;
                            drain_in_progress <= 1'b1;
                        end else if (fence_acq) begin
                            acq_pend      <= 1'b0;
                            state         <= INV_WALK;
                            walk_valid    <= 1'b1;
                            walk_inv      <= 1'b1;
                            ongoing_fence <= 1'b1;
                        end else begin
                            state      <= DONE;
                            fence_done <= 1'b1;
                        end
                    end
                end
                DRAIN_WALK: begin
                    if (walk_ready) begin
                        if (walk_idx == LAST_IDX) begin
                            walk_idx   <= '0;
                            walk_valid <= 1'b0;
                            state      <= DRAIN_WAIT;
                        end else begin
                            walk_idx <= walk_idx + 1'b1;
                        end
                    end
                end
                DRAIN_WAIT: begin
                    // a writeback issued this cycle is not yet in wb_cnt, so wait for it too
                    if (wb_cnt == '0 && !wb_issued) begin
                        ongoing_drain     <= 1'b1;
                        drain_in_progress <= 1'b0;
                        if (acq_pend) begin
                            state      <= INV_WALK;
                            walk_valid <= 1'b1;
                            walk_inv   <= 1'b1;
                        end else begin
                            state         <= DONE;
                            ongoing_fence <= 1'b0;
                            fence_done    <= 1'b1;
                        end
                    end
                end
                INV_WALK: begin
                    if (walk_ready) begin
                        if (walk_idx == LAST_IDX) begin
                            walk_idx      <= '0;
                            walk_valid    <= 1'b0;
                            walk_inv      <= 1'b0;
                            ongoing_fence <= 1'b0;
                            fence_done    <= 1'b1;
                            state         <= DONE;
                        end else begin
                            walk_idx <= walk_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state             <= IDLE;
                    walk_valid        <= 1'b0;
                    walk_inv          <= 1'b0;
                    ongoing_fence     <= 1'b0;
                    drain_in_progress <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding writebacks; runs in every state since acks can trail the fence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_cnt <= '0;
            wb_err <= 1'b0;
        end else begin
            case ({wb_issued, wb_acked})
                2'b10: begin
                    if (wb_cnt == {WB_CNT_BITS{1'b1}}) begin
                        wb_err <= 1'b1;
                    end else begin
                        wb_cnt <= wb_cnt + 1'b1;
                    end
                end
                2'b01: begin
                    if (wb_cnt == '0) begin
                        wb_err <= 1'b1;
                    end else begin
                        wb_cnt <= wb_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_fence_ctrl.sv
// tb/tb_l2_fence_ctrl.sv - directed self-checking bench for l2_fence_ctrl
module tb_l2_fence_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fence_start = 1'b0;
    logic       fence_rel = 1'b0;
    logic       fence_acq = 1'b0;
    logic       walk_valid;
    logic       walk_ready = 1'b0;
    logic [7:0] walk_set;
    logic [2:0] walk_way;
    logic       walk_inv;
    logic       wb_issued = 1'b0;
    logic       wb_acked = 1'b0;
    logic       clr_ongoing_drain = 1'b0;
    logic       ongoing_fence;
    logic       drain_in_progress;
    logic       ongoing_drain;
    logic       fence_done;
    logic       wb_err;

    logic [10:0] cur_idx;
    logic [17:0] all_out;

    int checks = 0;
    int failures = 0;

    assign cur_idx = {walk_set, walk_way};
    assign all_out = {walk_valid, walk_set, walk_way, walk_inv, ongoing_fence,
                      drain_in_progress, ongoing_drain, fence_done, wb_err};

    always #5 clk = ~clk;

    l2_fence_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .fence_start       (fence_start),
        .fence_rel         (fence_rel),
        .fence_acq         (fence_acq),
        .walk_valid        (walk_valid),
        .walk_ready        (walk_ready),
        .walk_set          (walk_set),
        .walk_way          (walk_way),
        .walk_inv          (walk_inv),
        .wb_issued         (wb_issued),
        .wb_acked          (wb_acked),
        .clr_ongoing_drain (clr_ongoing_drain),
        .ongoing_fence     (ongoing_fence),
        .drain_in_progress (drain_in_progress),
        .ongoing_drain     (ongoing_drain),
        .fence_done        (fence_done),
        .wb_err            (wb_err)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bit found;
        rst = 1'b0;
        tick;
        tick;
        checks++;
        if (all_out !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0", all_out);
        end
        rst = 1'b1;
        tick;
        fence_start = 1'b1;
        fence_acq   = 1'b1;
        walk_ready  = 1'b1;
        tick;
        fence_start = 1'b0;
        fence_acq   = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (walk_valid && cur_idx == 11'd43) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_reach_5_3: got idx %0d expected 43", cur_idx);
        end
        walk_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (all_out !== 18'h0 || dut.state !== 3'd0 || dut.wb_cnt !== 6'd0) begin
            failures++;
            $display("FAIL reset_mid_walk: got out %0h state %0d expected 0 0", all_out, dut.state);
        end
        tick;
        rst = 1'b1;
        tick;
        fence_start = 1'b1;
        fence_acq   = 1'b1;
        tick;
        fence_start = 1'b0;
        fence_acq   = 1'b0;
        checks++;
        if (walk_valid !== 1'b1 || cur_idx !== 11'd0 || walk_inv !== 1'b1) begin
            failures++;
            $display("FAIL reset_restart: got valid %0b idx %0d inv %0b expected 1 0 1",
                     walk_valid, cur_idx, walk_inv);
        end
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_drain_release;
        int steps;
        int bad;
        steps = 0;
        bad = 0;
        fence_start = 1'b1;
        fence_rel   = 1'b1;
        walk_ready  = 1'b1;
        tick;
        fence_start = 1'b0;
        fence_rel   = 1'b0;
        while (walk_valid && steps < 3000) begin
            if (!drain_in_progress || walk_inv || !ongoing_fence) bad++;
            wb_issued = (cur_idx == 11'd10 || cur_idx == 11'd500 || cur_idx == 11'd2000);
            steps++;
            tick;
        end
        wb_issued = 1'b0;
        checks++;
        if (steps != 2048) begin
            failures++;
            $display("FAIL drain_steps: got %0d expected 2048", steps);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL drain_walk_status: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (dut.wb_cnt !== 6'd3) begin
            failures++;
            $display("FAIL drain_wb_cnt: got %0d expected 3", dut.wb_cnt);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!drain_in_progress || fence_done || walk_valid) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL drain_wait_hold: got %0d bad cycles expected 0", bad);
        end
        wb_acked = 1'b1;
        tick;
        tick;
        tick;
        wb_acked = 1'b0;
        checks++;
        if (drain_in_progress !== 1'b1 || ongoing_drain !== 1'b0) begin
            failures++;
            $display("FAIL drain_last_ack: got dip %0b od %0b expected 1 0",
                     drain_in_progress, ongoing_drain);
        end
        tick;
        checks++;
        if (drain_in_progress !== 1'b0 || ongoing_drain !== 1'b1 || fence_done !== 1'b1 ||
            ongoing_fence !== 1'b0) begin
            failures++;
            $display("FAIL drain_complete: got dip %0b od %0b fd %0b of %0b expected 0 1 1 0",
                     drain_in_progress, ongoing_drain, fence_done, ongoing_fence);
        end
        tick;
        checks++;
        if (fence_done !== 1'b0 || ongoing_fence !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL drain_after: got fd %0b of %0b err %0b expected 0 0 0",
                     fence_done, ongoing_fence, wb_err);
        end
    endtask

    task automatic test_rel_acq;
        int drain;
        int inv;
        int bad;
        bit found;
        drain = 0;
        inv = 0;
        bad = 0;
        found = 1'b0;
        clr_ongoing_drain = 1'b1;
        tick;
        clr_ongoing_drain = 1'b0;
        checks++;
        if (ongoing_drain !== 1'b0) begin
            failures++;
            $display("FAIL clr_drain: got %0b expected 0", ongoing_drain);
        end
        fence_start = 1'b1;
        fence_rel   = 1'b1;
        fence_acq   = 1'b1;
        walk_ready  = 1'b1;
        tick;
        fence_start = 1'b0;
        fence_rel   = 1'b0;
        fence_acq   = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (fence_done) begin
                found = 1'b1;
                break;
            end
            if (walk_valid && !walk_inv) begin
                drain++;
                if (inv != 0 || !drain_in_progress) bad++;
            end
            if (walk_valid && walk_inv) begin
                inv++;
                if (drain_in_progress || !ongoing_fence) bad++;
            end
            tick;
        end
        checks++;
        if (!found || drain != 2048 || inv != 2048) begin
            failures++;
            $display("FAIL rel_acq_steps: got done %0b drain %0d inv %0d expected 1 2048 2048",
                     found, drain, inv);
        end
        checks++;
        if (bad != 0 || ongoing_drain !== 1'b1) begin
            failures++;
            $display("FAIL rel_acq_status: got bad %0d od %0b expected 0 1", bad, ongoing_drain);
        end
        tick;
        checks++;
        if (fence_done !== 1'b0) begin
            failures++;
            $display("FAIL rel_acq_pulse: got %0b expected 0", fence_done);
        end
    endtask

    task automatic test_acq_toggle;
        int cyc;
        int exp_idx;
        int mism;
        cyc = 1;
        exp_idx = 0;
        mism = 0;
        walk_ready  = 1'b0;
        fence_start = 1'b1;
        fence_acq   = 1'b1;
        tick;
        fence_start = 1'b0;
        fence_acq   = 1'b0;
        while (!fence_done && cyc < 5000) begin
            walk_ready = cyc[0];
            if (!walk_valid || !walk_inv || int'(cur_idx) != exp_idx) mism++;
            if (walk_ready) exp_idx++;
            tick;
            cyc++;
        end
        walk_ready = 1'b0;
        checks++;
        if (fence_done !== 1'b1 || cyc != 4096) begin
            failures++;
            $display("FAIL acq_toggle_latency: got done %0b cycles %0d expected 1 4096",
                     fence_done, cyc);
        end
        checks++;
        if (mism != 0 || exp_idx != 2048) begin
            failures++;
            $display("FAIL acq_toggle_seq: got %0d mismatches %0d steps expected 0 2048",
                     mism, exp_idx);
        end
        tick;
    endtask

    task automatic test_wb_cnt;
        wb_issued = 1'b1;
        tick;
        tick;
        wb_issued = 1'b0;
        checks++;
        if (dut.wb_cnt !== 6'd2) begin
            failures++;
            $display("FAIL wb_cnt_inc: got %0d expected 2", dut.wb_cnt);
        end
        wb_issued = 1'b1;
        wb_acked  = 1'b1;
        tick;
        wb_issued = 1'b0;
        wb_acked  = 1'b0;
        checks++;
        if (dut.wb_cnt !== 6'd2 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL wb_cnt_both: got %0d err %0b expected 2 0", dut.wb_cnt, wb_err);
        end
        wb_acked = 1'b1;
        tick;
        tick;
        wb_acked = 1'b0;
        checks++;
        if (dut.wb_cnt !== 6'd0 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL wb_cnt_dec: got %0d err %0b expected 0 0", dut.wb_cnt, wb_err);
        end
        wb_acked = 1'b1;
        tick;
        wb_acked = 1'b0;
        checks++;
        if (dut.wb_cnt !== 6'd0 || wb_err !== 1'b1) begin
            failures++;
            $display("FAIL wb_cnt_underflow: got %0d err %0b expected 0 1", dut.wb_cnt, wb_err);
        end
    endtask

    task automatic test_null_fence_and_clr;
        int steps;
        steps = 0;
        fence_start = 1'b1;
        tick;
        fence_start = 1'b0;
        checks++;
        if (fence_done !== 1'b1 || walk_valid !== 1'b0 || ongoing_fence !== 1'b0) begin
            failures++;
            $display("FAIL null_fence: got fd %0b valid %0b of %0b expected 1 0 0",
                     fence_done, walk_valid, ongoing_fence);
        end
        tick;
        checks++;
        if (fence_done !== 1'b0 || walk_valid !== 1'b0) begin
            failures++;
            $display("FAIL null_fence_pulse: got fd %0b valid %0b expected 0 0",
                     fence_done, walk_valid);
        end
        clr_ongoing_drain = 1'b1;
        tick;
        clr_ongoing_drain = 1'b0;
        fence_start = 1'b1;
        fence_rel   = 1'b1;
        walk_ready  = 1'b1;
        tick;
        fence_start = 1'b0;
        fence_rel   = 1'b0;
        while (walk_valid && steps < 3000) begin
            steps++;
            tick;
        end
        checks++;
        if (drain_in_progress !== 1'b1 || ongoing_drain !== 1'b0 || steps != 2048) begin
            failures++;
            $display("FAIL clr_setup: got dip %0b od %0b steps %0d expected 1 0 2048",
                     drain_in_progress, ongoing_drain, steps);
        end
        clr_ongoing_drain = 1'b1;
        tick;
        clr_ongoing_drain = 1'b0;
        checks++;
        if (ongoing_drain !== 1'b1 || fence_done !== 1'b1) begin
            failures++;
            $display("FAIL set_wins_clr: got od %0b fd %0b expected 1 1", ongoing_drain, fence_done);
        end
        clr_ongoing_drain = 1'b1;
        tick;
        clr_ongoing_drain = 1'b0;
        checks++;
        if (ongoing_drain !== 1'b0) begin
            failures++;
            $display("FAIL clr_after: got %0b expected 0", ongoing_drain);
        end
        walk_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_drain_release;
        test_rel_acq;
        test_acq_toggle;
        test_wb_cnt;
        test_null_fence_and_clr;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
